// File: rtl/pc_adder_pkg.sv
// Shared processor constants for the PC adder datapath.
package pc_adder_pkg;

  // Default operand / sum width of the PC adder.
  localparam int unsigned PC_WIDTH  = 32;

  // Bit width of one carry-lookahead group.
  localparam int unsigned CLA_GROUP = 4;

endpackage : pc_adder_pkg

// File: rtl/pc_adder_cla4.sv
// 4-bit carry-lookahead adder group: produces the group sum together with
// group generate/propagate so the parent can chain carries between groups.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       g,
  output logic       p,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  // Bit generate/propagate, flattened lookahead carries, group G/P and sum.
  always_comb begin
    w_g = a & b;
    w_p = a ^ b;

    w_c[0] = cin;
    w_c[1] = w_g[0] | (w_p[0] & cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);

    g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
      | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    p = &w_p;

    cout = g | (p & cin);
    s    = w_p ^ w_c;
  end

endmodule : cla4

// File: rtl/pc_adder.sv
// Registered PC adder: WIDTH-bit add built from 4-bit CLA groups with
// group carries rippled between them; 1-cycle latency, 1 result per cycle.
module pc_adder
  import pc_adder_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid
);

  localparam int unsigned NGRP = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] w_sum;
  logic [NGRP:0]    w_carry;
  logic [NGRP:0]    w_la_carry;
  logic [NGRP-1:0]  w_cout;
  logic [NGRP-1:0]  w_grp_g;
  logic [NGRP-1:0]  w_grp_p;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_valid;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_cla
    cla4 u_cla4 (
      .a    (a[gi*CLA_GROUP +: CLA_GROUP]),
      .b    (b[gi*CLA_GROUP +: CLA_GROUP]),
      .cin  (w_carry[gi]),
      .s    (w_sum[gi*CLA_GROUP +: CLA_GROUP]),
      .g    (w_grp_g[gi]),
      .p    (w_grp_p[gi]),
      .cout (w_cout[gi])
    );
  end

  // Ripple group carries; also rebuild them from group G/P as a cross-check.
  always_comb begin
    w_carry[0]    = 1'b0;
    w_la_carry[0] = 1'b0;
    for (int unsigned i = 0; i < NGRP; i++) begin
      w_carry[i+1]    = w_cout[i];
      w_la_carry[i+1] = w_grp_g[i] | (w_grp_p[i] & w_la_carry[i]);
    end
  end

  // Signed overflow: operands agree in sign but the sum does not.
  always_comb begin
    w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Output registers: capture on valid input, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry[NGRP];
        r_ovf   <= w_ovf;
      end
    end
  end

  // Group G/P chain must agree with the rippled cout chain at every sampling edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (w_la_carry == w_carry);
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;
  assign out_valid = r_valid;

endmodule : pc_adder

// File: tb/tb_pc_adder.sv
// Scoreboard bench for pc_adder: the driver pushes reference results, a
// monitor pops and compares whenever a result is due.
module tb_pc_adder;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         out_valid;

  exp_t sb_q[$];
  exp_t hold_exp;
  int   n_vec;
  int   n_err;

  pc_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain (W+1)-bit unsigned add and range check on the signed sum.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W:0]   full;
    longint       t;
    full  = {1'b0, x} + {1'b0, y};
    t     = longint'($signed(x)) + longint'($signed(y));
    e.sum = full[W-1:0];
    e.c   = full[W];
    e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic v);
    @(negedge clk);
    a        = x;
    b        = y;
    in_valid = v;
    if (v && rst_n) sb_q.push_back(model(x, y));
  endtask

  // Monitor: one result due per edge iff something was pushed before it.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_carry", 64'(carry_out), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
    end else begin
      check("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
      if (sb_q.size() > 0) hold_exp = sb_q.pop_front();
      check("sum", 64'(sum), 64'(hold_exp.sum));
      check("carry_out", 64'(carry_out), 64'(hold_exp.c));
      check("overflow", 64'(overflow), 64'(hold_exp.ovf));
    end
  end

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("async_sum", 64'(sum), 64'd0);
    check("async_carry", 64'(carry_out), 64'd0);
    check("async_ovf", 64'(overflow), 64'd0);
    check("async_valid", 64'(out_valid), 64'd0);
    sb_q.delete();
    hold_exp = '0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] pc;
    n_vec    = 0;
    n_err    = 0;
    hold_exp = '0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;

    // Reset held with random valid traffic: nothing may come out.
    for (int i = 0; i < 4; i++) drive($urandom, $urandom, 1'b1);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    drive($urandom, $urandom, 1'b0);
    drive($urandom, $urandom, 1'b0);

    // Basic adds, wrap, signed overflow.
    drive(32'd1234, 32'd3124, 1'b1);
    drive(32'd9000, 32'd1000, 1'b1);
    drive(32'hFFFF_FFFF, 32'd1, 1'b1);
    drive(32'h7FFF_FFFF, 32'd1, 1'b1);
    drive(32'h8000_0000, 32'h8000_0000, 1'b1);

    // Hold: data must stay while inputs wander with in_valid low.
    drive($urandom, $urandom, 1'b0);
    drive($urandom, $urandom, 1'b0);

    // PC increment stream with the reference sum fed back.
    pc = 32'h0040_0000;
    for (int i = 0; i < 8; i++) begin
      drive(pc, 32'd4, 1'b1);
      pc = model(pc, 32'd4).sum;
    end
    check("pc_final", 64'(pc), 64'h0040_0020);

    // Async reset between edges after a result is visible.
    drive(32'd5, 32'd6, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    async_reset_pulse();

    // Pending input discarded by a reset before its capture edge.
    drive(32'd11, 32'd22, 1'b1);
    in_valid = 1'b0;
    async_reset_pulse();
    drive(32'd100, 32'd200, 1'b1);
    drive($urandom, $urandom, 1'b0);

    // Random operands with occasional idle cycles.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom, $urandom, ($urandom_range(0, 7) != 0));
    end

    drive('0, '0, 1'b0);
    drive('0, '0, 1'b0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_pc_adder
